pipe_rate_change_ctrl: RTL and testbench

Sequences a PIPE rate change (Gen1..Gen5) across all PHY lanes on behalf of the LTSSM. Sits between the main LTSSM and the PIPE command/status interface. Owns `Rate`, `PCLKRate`, `PclkChangeAck` and `width`, and forces TX electrical idle while the change is in flight. Collects per-lane `PhyStatus` completion, then reports done or error back to the LTSSM.

---
 rtl/pcie_pipe_pkg.sv | 38 +++
 rtl/pipe_rate_change_ctrl_if.sv | 29 ++
 rtl/phystatus_collector.sv | 32 +++
 rtl/pipe_rate_change_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_rate_change_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pcie_pipe_pkg.sv
// Shared types and helpers for the PIPE rate-change controller:
// FSM state encoding, PIPE width codes and gen -> rate/width mapping.
package pcie_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE, EIDLE, SET_RATE, WAIT_OK, ACK, WAIT_PHY, FINISH
    } state_t;

    localparam logic [1:0] WIDTH_8  = 2'd0;
    localparam logic [1:0] WIDTH_16 = 2'd1;
    localparam logic [1:0] WIDTH_32 = 2'd2;

    function automatic logic [1:0] width_bits_code(input int bits);
        case (bits)
            16:      return WIDTH_16;
            32:      return WIDTH_32;
            default: return WIDTH_8;
        endcase
    endfunction

    // Width code of a generation, given the per-gen data widths in bits.
    function automatic logic [1:0] pipe_width_code(input logic [2:0] gen,
                                                   input int w1, input int w2, input int w3,
                                                   input int w4, input int w5);
        case (gen)
            3'd2:    return width_bits_code(w2);
            3'd3:    return width_bits_code(w3);
            3'd4:    return width_bits_code(w4);
            3'd5:    return width_bits_code(w5);
            default: return width_bits_code(w1);
        endcase
    endfunction

    function automatic logic [3:0] gen_to_rate(input logic [2:0] gen);
        return {1'b0, gen - 3'd1};
    endfunction

endpackage

// File: rtl/pipe_rate_change_ctrl_if.sv
// LTSSM request/status and PIPE command/status signals of the rate-change controller.
interface pipe_rate_change_ctrl_if #(parameter int LANESNUMBER = 16);
    logic                   req_valid;
    logic [2:0]             req_gen;
    logic                   req_ready;
    logic [LANESNUMBER-1:0] active_lanes;
    logic [LANESNUMBER-1:0] PhyStatus;
    logic                   PclkChangeOk;
    logic [3:0]             Rate;
    logic [4:0]             PCLKRate;
    logic                   PclkChangeAck;
    logic [1:0]             width;
    logic                   tx_eidle_force;
    logic [2:0]             cur_gen;
    logic                   done;
    logic                   error;

    modport master (
        output req_valid, req_gen, active_lanes, PhyStatus, PclkChangeOk,
        input  req_ready, Rate, PCLKRate, PclkChangeAck, width, tx_eidle_force,
               cur_gen, done, error
    );

    modport slave (
        input  req_valid, req_gen, active_lanes, PhyStatus, PclkChangeOk,
        output req_ready, Rate, PCLKRate, PclkChangeAck, width, tx_eidle_force,
               cur_gen, done, error
    );
endinterface

// File: rtl/phystatus_collector.sv
// Per-lane sticky PhyStatus collector against a mask latched at request acceptance.
module phystatus_collector #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] mask_in,
    input  logic         clear,
    input  logic [N-1:0] phy_status,
    output logic         all_done
);
    logic [N-1:0] mask;
    logic [N-1:0] sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask   <= '0;
            sticky <= '0;
        end else begin
            if (load)
                mask <= mask_in;
            if (clear)
                sticky <= '0;
            else
                sticky <= sticky | phy_status;
        end
    end

    // Live pulses are folded in so a same-cycle completion is not delayed.
    assign all_done = ((sticky | phy_status) & mask) == mask;
endmodule

// File: rtl/pipe_rate_change_ctrl.sv
// PIPE rate-change sequencer (EIDLE -> rate -> PCLK handshake -> PhyStatus collect).
// Optional WAIT_OK/WAIT_PHY watchdog with rollback: define RATE_CHG_TIMEOUT_EN.
module pipe_rate_change_ctrl
    import pcie_pipe_pkg::*;
#(
    parameter int LANESNUMBER    = 16,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8,
    parameter int MAX_GEN        = 1,
    parameter int EIDLE_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    CLK,
    input  logic                    lpreset,
    pipe_rate_change_ctrl_if.slave  bus
);
    localparam int         EW         = $clog2(EIDLE_CYCLES + 1);
    localparam logic [EW-1:0] EIDLE_LAST = EW'(EIDLE_CYCLES - 1);
    localparam logic [2:0] MAX_G      = 3'(MAX_GEN);

    function automatic logic [1:0] wcode(input logic [2:0] g);
        return pipe_width_code(g, GEN1_PIPEWIDTH, GEN2_PIPEWIDTH, GEN3_PIPEWIDTH,
                               GEN4_PIPEWIDTH, GEN5_PIPEWIDTH);
    endfunction

    state_t        state, state_n;
    logic [EW-1:0] cnt, cnt_n;
    logic [2:0]    tgt, tgt_n, prev, prev_n, cur, cur_n;
    logic [3:0]    rate, rate_n;
    logic [1:0]    wid, wid_n;
    logic          pend_done, pend_done_n, pend_err, pend_err_n;
    logic          ack, ack_n, eidle, eidle_n, done_q, done_n, err_q, err_n;
    logic          load, clear, all_done, wd_hit, abort;

    phystatus_collector #(.N(LANESNUMBER)) u_coll (
        .clk       (CLK),
        .rst       (lpreset),
        .load      (load),
        .mask_in   (bus.active_lanes),
        .clear     (clear),
        .phy_status(bus.PhyStatus),
        .all_done  (all_done)
    );

`ifdef RATE_CHG_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    logic [WW-1:0] wd;

    // Reloads on every state change, so each wait state gets a full budget.
    always_ff @(posedge CLK) begin
        if (lpreset || state_n != state)
            wd <= '0;
        else if (state == WAIT_OK || state == WAIT_PHY)
            wd <= wd + 1'b1;
    end
    assign wd_hit = (wd == WW'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: a wait never times out (TIMEOUT_CYCLES is always >= 2).
    assign wd_hit = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tgt_n       = tgt;
        prev_n      = prev;
        cur_n       = cur;
        rate_n      = rate;
        wid_n       = wid;
        pend_done_n = pend_done;
        pend_err_n  = pend_err;
        ack_n       = ack;
        eidle_n     = eidle;
        done_n      = 1'b0;
        err_n       = 1'b0;
        load        = 1'b0;
        clear       = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (bus.req_gen == 3'd0 || bus.req_gen > MAX_G) begin
                    pend_err_n = 1'b1;
                    state_n    = FINISH;
                end else if (bus.req_gen == cur) begin
                    pend_done_n = 1'b1;
                    state_n     = FINISH;
                end else begin
                    tgt_n   = bus.req_gen;
                    prev_n  = cur;
                    load    = 1'b1;
                    eidle_n = 1'b1;
                    cnt_n   = '0;
                    state_n = EIDLE;
                end
            end
            EIDLE: begin
                if (cnt == EIDLE_LAST) state_n = SET_RATE;
                else                   cnt_n   = cnt + 1'b1;
            end
            SET_RATE: begin
                rate_n  = gen_to_rate(tgt);
                wid_n   = wcode(tgt);
                cur_n   = tgt;
                state_n = WAIT_OK;
            end
            WAIT_OK: begin
                if (bus.PclkChangeOk) begin
                    ack_n   = 1'b1;
                    state_n = ACK;
                end else
                    abort = wd_hit;
            end
            ACK: begin
                clear   = 1'b1;
                state_n = WAIT_PHY;
            end
            WAIT_PHY: begin
                if (all_done) begin
                    done_n  = 1'b1;
                    ack_n   = 1'b0;
                    eidle_n = 1'b0;
                    state_n = FINISH;
                end else
                    abort = wd_hit;
            end
            FINISH: begin
                // Fast-path (invalid / same-gen) results surface on FINISH exit.
                done_n      = pend_done;
                err_n       = pend_err;
                pend_done_n = 1'b0;
                pend_err_n  = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            err_n   = 1'b1;
            ack_n   = 1'b0;
            eidle_n = 1'b0;
            rate_n  = gen_to_rate(prev);
            wid_n   = wcode(prev);
            cur_n   = prev;
            state_n = FINISH;
        end
    end

    always_ff @(posedge CLK) begin
        if (lpreset) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= 3'd1;
            prev      <= 3'd1;
            cur       <= 3'd1;
            rate      <= 4'd0;
            wid       <= wcode(3'd1);
            pend_done <= 1'b0;
            pend_err  <= 1'b0;
            ack       <= 1'b0;
            eidle     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tgt       <= tgt_n;
            prev      <= prev_n;
            cur       <= cur_n;
            rate      <= rate_n;
            wid       <= wid_n;
            pend_done <= pend_done_n;
            pend_err  <= pend_err_n;
            ack       <= ack_n;
            eidle     <= eidle_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    assign bus.req_ready      = (state == IDLE) && !lpreset;
    assign bus.Rate           = rate;
    assign bus.PCLKRate       = {1'b0, rate};
    assign bus.width          = wid;
    assign bus.cur_gen        = cur;
    assign bus.PclkChangeAck  = ack;
    assign bus.tx_eidle_force = eidle;
    assign bus.done           = done_q;
    assign bus.error          = err_q;
endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// Directed self-checking bench for pipe_rate_change_ctrl (MAX_GEN=3, Gen3 = 32-bit).
module tb_pipe_rate_change_ctrl;
    localparam int EC = 4;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic lpreset;
    int   total = 0;
    int   bad   = 0;

    pipe_rate_change_ctrl_if #(.LANESNUMBER(16)) bus ();

    pipe_rate_change_ctrl #(
        .LANESNUMBER(16), .GEN1_PIPEWIDTH(8), .GEN2_PIPEWIDTH(8), .GEN3_PIPEWIDTH(32),
        .GEN4_PIPEWIDTH(8), .GEN5_PIPEWIDTH(8), .MAX_GEN(3), .EIDLE_CYCLES(EC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .lpreset(lpreset), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // {Rate, PCLKRate, cur_gen, width, PclkChangeAck, tx_eidle_force, done, error}
    function automatic logic [17:0] outs();
        return {bus.Rate, bus.PCLKRate, bus.cur_gen, bus.width,
                bus.PclkChangeAck, bus.tx_eidle_force, bus.done, bus.error};
    endfunction

    localparam logic [17:0] RESET_OUTS = {4'd0, 5'd0, 3'd1, 2'd0, 4'b0000};

    task automatic test_reset();
        lpreset = 1'b1;
        bus.req_valid = 1'b0; bus.req_gen = 3'd0; bus.active_lanes = '0;
        bus.PhyStatus = '0;   bus.PclkChangeOk = 1'b0;
        repeat (3) tick();
        total++; if (outs() !== RESET_OUTS) begin bad++; $display("FAIL reset_outs got=%h exp=%h", outs(), RESET_OUTS); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b exp=0", bus.req_ready); end
        lpreset = 1'b0;
        tick();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_same_gen();
        int n = 0;
        bit eid = 0;
        bus.req_valid = 1'b1; bus.req_gen = 3'd1;
        while (n < 20) begin
            tick(); bus.req_valid = 1'b0; n++;
            eid |= bus.tx_eidle_force;
            if (bus.done === 1'b1 || bus.error === 1'b1) break;
        end
        total++; if (n !== 2) begin bad++; $display("FAIL same_gen_latency got=%0d exp=2", n); end
        total++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin bad++; $display("FAIL same_gen_result done=%b err=%b exp done=1 err=0", bus.done, bus.error); end
        total++; if (eid !== 1'b0) begin bad++; $display("FAIL same_gen_eidle got=%b exp=0", eid); end
        total++; if (bus.Rate !== 4'd0) begin bad++; $display("FAIL same_gen_rate got=%0d exp=0", bus.Rate); end
    endtask

    task automatic test_gen3();
        int n = 0;
        bit f1 = 0, rate_bad = 0;
        logic [3:0] last_rate = bus.Rate;
        bus.PclkChangeOk = 1'b1; bus.PhyStatus = '1; bus.active_lanes = '1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL gen3_ready got=%b exp=1", bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_gen = 3'd3;
        while (n < 200) begin
            tick(); bus.req_valid = 1'b0; n++;
            if (n == 1) f1 = bus.tx_eidle_force;
            if (bus.Rate !== last_rate && bus.tx_eidle_force !== 1'b1) rate_bad = 1;
            last_rate = bus.Rate;
            if (bus.done === 1'b1) break;
        end
        total++; if (n !== EC + 5) begin bad++; $display("FAIL gen3_latency got=%0d exp=%0d", n, EC + 5); end
        total++; if (f1 !== 1'b1) begin bad++; $display("FAIL gen3_eidle_rise got=%b exp=1", f1); end
        total++; if (rate_bad !== 1'b0) begin bad++; $display("FAIL gen3_rate_outside_eidle got=%b exp=0", rate_bad); end
        total++; if ({bus.Rate, bus.PCLKRate, bus.width, bus.cur_gen} !== {4'd2, 5'd2, 2'd2, 3'd3})
            begin bad++; $display("FAIL gen3_regs rate=%0d pclk=%0d width=%0d gen=%0d exp 2/2/2/3", bus.Rate, bus.PCLKRate, bus.width, bus.cur_gen); end
        bus.PhyStatus = '0;
        tick();
        total++; if ({bus.tx_eidle_force, bus.PclkChangeAck, bus.done} !== 3'b000)
            begin bad++; $display("FAIL gen3_after eidle=%b ack=%b done=%b exp 000", bus.tx_eidle_force, bus.PclkChangeAck, bus.done); end
    endtask

    task automatic test_mask();
        int n = 0;
        logic [15:0] pulses [4] = '{16'h0001, 16'h0002, 16'hFFF4, 16'h0008};
        bus.active_lanes = 16'h000F; bus.PclkChangeOk = 1'b1; bus.PhyStatus = '0;
        bus.req_valid = 1'b1; bus.req_gen = 3'd2;
        while (n < 100 && bus.PclkChangeAck !== 1'b1) begin tick(); bus.req_valid = 1'b0; n++; end
        total++; if (bus.PclkChangeAck !== 1'b1) begin bad++; $display("FAIL mask_ack_seen got=%b exp=1", bus.PclkChangeAck); end
        // Mask change and out-of-mask lanes must be ignored.
        bus.active_lanes = 16'hFFFF; bus.PhyStatus = 16'hFFF0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mask_early_done step=%0d got=%b exp=0", i, bus.done); end
            bus.PhyStatus = pulses[i];
        end
        tick();
        bus.PhyStatus = '0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL mask_done got=%b exp=1", bus.done); end
        total++; if ({bus.Rate, bus.width, bus.cur_gen} !== {4'd1, 2'd0, 3'd2})
            begin bad++; $display("FAIL mask_regs rate=%0d width=%0d gen=%0d exp 1/0/2", bus.Rate, bus.width, bus.cur_gen); end
        tick();
    endtask

    task automatic test_invalid();
        logic [2:0] gens [2] = '{3'd4, 3'd0};
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            bit eid = 0, dn = 0;
            bus.req_valid = 1'b1; bus.req_gen = gens[k];
            while (n < 20) begin
                tick(); bus.req_valid = 1'b0; n++;
                eid |= bus.tx_eidle_force; dn |= bus.done;
                if (bus.error === 1'b1) break;
            end
            total++; if (n !== 2 || bus.error !== 1'b1) begin bad++; $display("FAIL invalid_err gen=%0d lat=%0d err=%b exp lat=2 err=1", gens[k], n, bus.error); end
            total++; if ({eid, dn} !== 2'b00) begin bad++; $display("FAIL invalid_side gen=%0d eidle=%b done=%b exp 00", gens[k], eid, dn); end
            total++; if ({bus.Rate, bus.cur_gen} !== {4'd1, 3'd2}) begin bad++; $display("FAIL invalid_rate gen=%0d rate=%0d cur=%0d exp 1/2", gens[k], bus.Rate, bus.cur_gen); end
            tick();
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit ack_seen = 0, ended = 0;
        logic [3:0] rate_mid = 4'hF;
`ifdef RATE_CHG_TIMEOUT_EN
        lpreset = 1'b1; tick(); lpreset = 1'b0; tick();
        bus.PclkChangeOk = 1'b0; bus.PhyStatus = '0; bus.active_lanes = '1;
        bus.req_valid = 1'b1; bus.req_gen = 3'd2;
        while (n < 100) begin
            tick(); bus.req_valid = 1'b0; n++;
            ack_seen |= bus.PclkChangeAck;
            if (n == EC + 2) rate_mid = bus.Rate;
            if (bus.error === 1'b1 || bus.done === 1'b1) break;
        end
        total++; if (n !== EC + 2 + TO || bus.error !== 1'b1) begin bad++; $display("FAIL timeout_err lat=%0d err=%b exp lat=%0d err=1", n, bus.error, EC + 2 + TO); end
        total++; if (ack_seen !== 1'b0) begin bad++; $display("FAIL timeout_ack got=%b exp=0", ack_seen); end
        total++; if (rate_mid !== 4'd1) begin bad++; $display("FAIL timeout_rate_mid got=%0d exp=1", rate_mid); end
        total++; if ({bus.Rate, bus.width, bus.cur_gen} !== {4'd0, 2'd0, 3'd1})
            begin bad++; $display("FAIL timeout_revert rate=%0d width=%0d gen=%0d exp 0/0/1", bus.Rate, bus.width, bus.cur_gen); end
        tick();
`else
        // Without the watchdog the block must simply keep waiting.
        bus.PclkChangeOk = 1'b0; bus.PhyStatus = '0; bus.active_lanes = '1;
        bus.req_valid = 1'b1; bus.req_gen = 3'd3;
        while (n < 40) begin
            tick(); bus.req_valid = 1'b0; n++;
            ack_seen |= bus.PclkChangeAck;
            ended |= bus.done | bus.error;
        end
        total++; if ({ended, ack_seen} !== 2'b00) begin bad++; $display("FAIL wait_forever end=%b ack=%b exp 00", ended, ack_seen); end
        total++; if ({bus.tx_eidle_force, bus.Rate} !== {1'b1, 4'd2}) begin bad++; $display("FAIL wait_forever_state eidle=%b rate=%0d exp 1/2", bus.tx_eidle_force, bus.Rate); end
        bus.PclkChangeOk = 1'b1; bus.PhyStatus = '1;
        n = 0;
        while (n < 20 && bus.done !== 1'b1) begin tick(); n++; end
        bus.PhyStatus = '0;
        total++; if (bus.done !== 1'b1 || bus.cur_gen !== 3'd3) begin bad++; $display("FAIL wait_forever_done done=%b gen=%0d exp 1/3", bus.done, bus.cur_gen); end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bus.active_lanes = 16'h0001; bus.PclkChangeOk = 1'b1; bus.PhyStatus = '0;
        bus.req_valid = 1'b1; bus.req_gen = 3'd2;
        while (n < 100 && bus.PclkChangeAck !== 1'b1) begin tick(); bus.req_valid = 1'b0; n++; end
        tick();
        total++; if (bus.PclkChangeAck !== 1'b1) begin bad++; $display("FAIL rstmid_ack_hold got=%b exp=1", bus.PclkChangeAck); end
        lpreset = 1'b1;
        tick();
        total++; if (outs() !== RESET_OUTS) begin bad++; $display("FAIL rstmid_outs got=%h exp=%h", outs(), RESET_OUTS); end
        lpreset = 1'b0;
        tick();
        total++; if ({bus.req_ready, bus.done, bus.error} !== 3'b100) begin bad++; $display("FAIL rstmid_after ready=%b done=%b err=%b exp 100", bus.req_ready, bus.done, bus.error); end
    endtask

    initial begin
        test_reset();
        test_same_gen();
        test_gen3();
        test_mask();
        test_invalid();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
